regfile: RTL and testbench

- RV32I integer register file: 32 × 32-bit registers, x0 hardwired to zero.
- Two combinational (asynchronous) read ports (rs1, rs2) and one synchronous write port (rd).
- Sits in the decode/writeback stage of the single-clock riscv_rv32i core.
- Decode reads operands from it; writeback writes results into it.

---
 rtl/rv32i_pkg.sv | 13 +
 rtl/regfile_rd_port.sv | 29 ++
 rtl/regfile.sv | 75 +++++++
 tb/tb_regfile.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I constants and types
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port with x0 forcing and optional bypass
module regfile_rd_port
    import rv32i_pkg::*;
#(
    parameter int XLEN      = rv32i_pkg::XLEN,
    parameter int NUM_REGS  = rv32i_pkg::NUM_REGS,
    parameter int ADDR_W    = rv32i_pkg::REG_ADDR_W,
    parameter int BYPASS_EN = 0
) (
    input  logic [ADDR_W-1:0]               i_rs_addr,
    input  logic [NUM_REGS-1:0][XLEN-1:0]   i_regs,
    input  logic                            i_byp_valid,
    input  logic [ADDR_W-1:0]               i_rd_addr,
    input  logic [XLEN-1:0]                 i_rd_data,
    output logic [XLEN-1:0]                 o_rs_data
);

    // x0 and out-of-range indices read zero; a live write to the same index wins when forwarding is enabled
    always_comb begin
        o_rs_data = '0;
        if (i_rs_addr != ADDR_W'(REG_ZERO) && int'(i_rs_addr) < NUM_REGS) begin
            o_rs_data = i_regs[i_rs_addr];
        end
        if (BYPASS_EN != 0 && i_byp_valid && i_rs_addr == i_rd_addr) begin
            o_rs_data = i_rd_data;
        end
    end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - RV32I integer register file, two async reads, one sync write
module regfile
    import rv32i_pkg::*;
#(
    parameter int XLEN      = rv32i_pkg::XLEN,
    parameter int NUM_REGS  = rv32i_pkg::NUM_REGS,
    parameter int ADDR_W    = rv32i_pkg::REG_ADDR_W,
    parameter int BYPASS_EN = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    output logic [XLEN-1:0]   o_rs1_data,
    output logic [XLEN-1:0]   o_rs2_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [XLEN-1:0]   i_rd_data,
    input  logic              i_rd_wren
);

    logic                          wr_en;
    logic                          byp_valid;
    logic [NUM_REGS-1:0][XLEN-1:0] regs_flat;

    // writes to x0 are dropped here so neither storage nor bypass ever sees them
    assign wr_en     = i_rd_wren && (i_rd_addr != ADDR_W'(REG_ZERO));
    // forwarding must not leak a write that reset is about to discard
    assign byp_valid = wr_en && i_reset;

    assign regs_flat[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        logic [XLEN-1:0] q;

        // one storage word per architectural register; reset beats a simultaneous write
        always_ff @(posedge i_clk) begin
            if (!i_reset) begin
                q <= '0;
            end else if (wr_en && i_rd_addr == ADDR_W'(g)) begin
                q <= i_rd_data;
            end
        end

        assign regs_flat[g] = q;
    end

    regfile_rd_port #(
        .XLEN      (XLEN),
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_rs1 (
        .i_rs_addr   (i_rs1_addr),
        .i_regs      (regs_flat),
        .i_byp_valid (byp_valid),
        .i_rd_addr   (i_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_rs_data   (o_rs1_data)
    );

    regfile_rd_port #(
        .XLEN      (XLEN),
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_rs2 (
        .i_rs_addr   (i_rs2_addr),
        .i_regs      (regs_flat),
        .i_byp_valid (byp_valid),
        .i_rd_addr   (i_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_rs_data   (o_rs2_data)
    );

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - self-checking bench for regfile, both bypass configurations
module tb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        wren;
    logic [31:0] nb_rs1, nb_rs2, by_rs1, by_rs2;

    logic [31:0] model [32];
    int total = 0;
    int bad   = 0;

    regfile #(.BYPASS_EN(0)) dut_nb (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_rs1_addr (rs1),
        .i_rs2_addr (rs2),
        .o_rs1_data (nb_rs1),
        .o_rs2_data (nb_rs2),
        .i_rd_addr  (rd),
        .i_rd_data  (wdata),
        .i_rd_wren  (wren)
    );

    regfile #(.BYPASS_EN(1)) dut_by (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_rs1_addr (rs1),
        .i_rs2_addr (rs2),
        .o_rs1_data (by_rs1),
        .o_rs2_data (by_rs2),
        .i_rd_addr  (rd),
        .i_rd_data  (wdata),
        .i_rd_wren  (wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_read(input logic [4:0] a, input bit bypass);
        if (a == 5'd0) return 32'h0;
        if (bypass && rst === 1'b1 && wren === 1'b1 && rd != 5'd0 && a == rd) return wdata;
        return model[a];
    endfunction

    task automatic drive(input logic r, input logic we, input logic [4:0] a, input logic [31:0] d);
        rst = r; wren = we; rd = a; wdata = d;
    endtask

    // clock edge, then apply the architectural effect of the inputs that were live at it
    task automatic tick();
        @(posedge clk);
        if (rst === 1'b0) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (wren === 1'b1 && rd != 5'd0) begin
            model[rd] = wdata;
        end
        #1;
    endtask

    task automatic check_rd(input logic [4:0] a1, input logic [4:0] a2, input string tag);
        rs1 = a1; rs2 = a2;
        #1;
        chk({tag, "/nb_rs1"}, nb_rs1, expect_read(a1, 1'b0));
        chk({tag, "/nb_rs2"}, nb_rs2, expect_read(a2, 1'b0));
        chk({tag, "/by_rs1"}, by_rs1, expect_read(a1, 1'b1));
        chk({tag, "/by_rs2"}, by_rs2, expect_read(a2, 1'b1));
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, a, d);
        tick();
        wren = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rs1 = '0; rs2 = '0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);

        tick();
        tick();
        rst = 1'b1;
        check_rd(5'd0, 5'd31, "reset_0_31");
        check_rd(5'd5, 5'd0, "reset_x5");

        write(5'd5, 32'hDEADBEEF);
        check_rd(5'd5, 5'd0, "wr_x5");
        write(5'd10, 32'h12345678);
        check_rd(5'd10, 5'd5, "wr_x10");

        drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF);
        check_rd(5'd0, 5'd0, "x0_pending");
        tick();
        wren = 1'b0;
        check_rd(5'd0, 5'd0, "x0_after");
        write(5'd1, 32'hFFFFFFFF);
        check_rd(5'd1, 5'd0, "wr_x1");

        write(5'd5, 32'h0A0A0A0A);
        check_rd(5'd5, 5'd10, "overwrite_x5");
        write(5'd31, 32'hCAFEBABE);
        check_rd(5'd31, 5'd1, "wr_x31");
        write(5'd10, 32'h00000000);
        check_rd(5'd10, 5'd31, "clear_x10");

        drive(1'b1, 1'b0, 5'd15, 32'h55AA55AA);
        for (int i = 0; i < 3; i++) tick();
        check_rd(5'd15, 5'd5, "wren_off");
        write(5'd15, 32'h55AA55AA);
        check_rd(5'd15, 5'd5, "wr_x15");

        drive(1'b1, 1'b1, 5'd7, 32'h11112222);
        check_rd(5'd7, 5'd7, "raw_same_cycle");
        tick();
        wren = 1'b0;
        check_rd(5'd7, 5'd0, "raw_after");

        drive(1'b0, 1'b1, 5'd7, 32'h99999999);
        check_rd(5'd7, 5'd7, "rst_pending_wr");
        tick();
        drive(1'b1, 1'b0, 5'd0, 32'h0);
        check_rd(5'd7, 5'd31, "rst_priority");
        check_rd(5'd15, 5'd1, "rst_clears");

        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 24) != 0), 1'($urandom), 5'($urandom), $urandom);
            check_rd(5'($urandom), ($urandom_range(0, 3) == 0) ? rd : 5'($urandom), "rand_pre");
            tick();
        end

        drive(1'b1, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i += 2) begin
            check_rd(5'(i), 5'(i + 1), "final_sweep");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
